// File: rtl/flow_to_stream_if.sv
// ----------------------------------------------------------------------------
// flow_to_stream_if
// Bundles the two handshakes that cross the flow_to_stream adapter:
//   flow side   : flow_valid, flow_data      (no backpressure)
//   stream side : stream_valid, stream_data, stream_ready
// Modports:
//   master : the environment. It drives the flow beats and stream_ready, and
//            observes the stream output.
//   slave  : the adapter. It receives the flow beats and drives the stream
//            output.
// ----------------------------------------------------------------------------
interface flow_to_stream_if #(
    parameter type T = logic [31:0]
);
    logic flow_valid;
    T     flow_data;
    logic stream_valid;
    T     stream_data;
    logic stream_ready;

    modport master (
        output flow_valid,
        output flow_data,
        output stream_ready,
        input  stream_valid,
        input  stream_data
    );

    modport slave (
        input  flow_valid,
        input  flow_data,
        input  stream_ready,
        output stream_valid,
        output stream_data
    );
endinterface

// File: rtl/flow_to_stream.sv
// ----------------------------------------------------------------------------
// flow_to_stream
// Adapts a free-running flow source (no backpressure) to a backpressured
// stream sink. Beats are queued in a DEPTH-entry circular buffer that feeds a
// registered output stage, so total capacity is DEPTH+1. A beat that cannot
// be stored is dropped: buffered beats are never overwritten. Every drop sets
// a sticky overflow flag and, optionally, bumps a saturating drop counter.
//
// Ports:
//   i_clock      : single clock, rising edge
//   i_reset      : synchronous, active-high reset
//   io_bus       : flow_to_stream_if.slave (flow in, stream out)
//   i_clear      : clears o_overflow and o_drop_count
//   o_overflow   : sticky, at least one beat dropped since reset/clear
//   o_drop_count : saturating count of dropped beats
//
// Build option:
//   FLOW_TO_STREAM_DROP_COUNT_EN defined   -> drop counter implemented
//   FLOW_TO_STREAM_DROP_COUNT_EN undefined -> o_drop_count tied to 0
// ----------------------------------------------------------------------------
module flow_to_stream #(
    parameter type         T           = logic [31:0],
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    flow_to_stream_if.slave        io_bus,
    input  logic                   i_clear,
    output logic                   o_overflow,
    output logic [COUNT_WIDTH-1:0] o_drop_count
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    T                  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic              r_valid;
    T                  r_data;
    logic              r_overflow;

    logic              w_read;
    logic              w_accept;
    logic              w_drop;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;

    // Output register is free when empty or being consumed this cycle.
    assign w_read   = (!r_valid || io_bus.stream_ready) && (r_fill != '0);
    // A full buffer still takes a beat when the head leaves in the same cycle.
    assign w_accept = io_bus.flow_valid && ((r_fill < FILL_W'(DEPTH)) || w_read);
    assign w_drop   = io_bus.flow_valid && !w_accept;

    // Explicit wrap so DEPTH need not be a power of two.
    assign w_wr_ptr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    // Storage and output payload carry no reset; validity is tracked separately.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= io_bus.flow_data;
            end
            if (w_read) begin
                r_data <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_read) begin
                r_rd_ptr <= w_rd_ptr_next;
                r_valid  <= 1'b1;
            end else if (io_bus.stream_ready) begin
                r_valid  <= 1'b0;
            end
            case ({w_accept, w_read})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
            // A drop in the same cycle as clear wins.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef FLOW_TO_STREAM_DROP_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_drop_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            if (i_clear) begin
                r_drop_count <= COUNT_WIDTH'(1);
            end else if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
            end
        end else if (i_clear) begin
            r_drop_count <= '0;
        end
    end

    assign o_drop_count = r_drop_count;
`else
    assign o_drop_count = '0;
`endif

    assign io_bus.stream_valid = r_valid;
    assign io_bus.stream_data  = r_data;
    assign o_overflow          = r_overflow;
endmodule

// File: tb/tb_flow_to_stream.sv
// ----------------------------------------------------------------------------
// tb_flow_to_stream
// Drives two adapters from the same stimulus: A (DEPTH=4, COUNT_WIDTH=4) and
// B (DEPTH=3, COUNT_WIDTH=16, non power-of-two wrap). Each is compared every
// cycle against a queue-based reference model, with directed constant checks
// for the documented scenarios on A, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_flow_to_stream;
`ifdef FLOW_TO_STREAM_DROP_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        ovf_a, ovf_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    flow_to_stream_if #(.T(logic [31:0])) ifa ();
    flow_to_stream_if #(.T(logic [31:0])) ifb ();

    flow_to_stream #(.T(logic [31:0]), .DEPTH(4), .COUNT_WIDTH(4)) dut_a (
        .i_clock     (clk),
        .i_reset     (rst),
        .io_bus      (ifa.slave),
        .i_clear     (clr),
        .o_overflow  (ovf_a),
        .o_drop_count(cnt_a)
    );

    flow_to_stream #(.T(logic [31:0]), .DEPTH(3), .COUNT_WIDTH(16)) dut_b (
        .i_clock     (clk),
        .i_reset     (rst),
        .io_bus      (ifb.slave),
        .i_clear     (clr),
        .o_overflow  (ovf_b),
        .o_drop_count(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model: buffer contents as a queue, output stage as a register.
    logic [31:0] m_q [2][$];
    bit          m_valid [2];
    logic [31:0] m_data [2];
    bit          m_ovf [2];
    int unsigned m_cnt [2];
    int unsigned m_depth [2] = '{4, 3};
    int unsigned m_cmax [2]  = '{15, 65535};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input logic rv, input logic [31:0] d,
                              input logic rdy, input logic c, input logic r);
        bit rd, acc, drp;
        if (r) begin
            m_q[i].delete();
            m_valid[i] = 1'b0;
            m_ovf[i]   = 1'b0;
            m_cnt[i]   = 0;
            return;
        end
        rd  = (!m_valid[i] || rdy) && (m_q[i].size() != 0);
        acc = rv && ((m_q[i].size() < m_depth[i]) || rd);
        drp = rv && !acc;
        if (rd) begin
            m_data[i]  = m_q[i].pop_front();
            m_valid[i] = 1'b1;
        end else if (rdy) begin
            m_valid[i] = 1'b0;
        end
        if (acc) m_q[i].push_back(d);
        if (drp) begin
            m_ovf[i] = 1'b1;
            if (CntEn) m_cnt[i] = c ? 1 : ((m_cnt[i] < m_cmax[i]) ? m_cnt[i] + 1 : m_cnt[i]);
        end else if (c) begin
            m_ovf[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("a_valid", 64'(ifa.stream_valid), 64'(m_valid[0]));
        if (m_valid[0]) chk("a_data", 64'(ifa.stream_data), 64'(m_data[0]));
        chk("a_overflow", 64'(ovf_a), 64'(m_ovf[0]));
        chk("a_drop_count", 64'(cnt_a), 64'(m_cnt[0]));
        chk("b_valid", 64'(ifb.stream_valid), 64'(m_valid[1]));
        if (m_valid[1]) chk("b_data", 64'(ifb.stream_data), 64'(m_data[1]));
        chk("b_overflow", 64'(ovf_b), 64'(m_ovf[1]));
        chk("b_drop_count", 64'(cnt_b), 64'(m_cnt[1]));
    endtask

    // One clock cycle: drive, advance model on the edge, sample 1 time unit later.
    task automatic step(input logic rv, input logic [31:0] d, input logic rdy,
                        input logic c, input logic r);
        ifa.flow_valid   = rv;
        ifa.flow_data    = d;
        ifa.stream_ready = rdy;
        ifb.flow_valid   = rv;
        ifb.flow_data    = d;
        ifb.stream_ready = rdy;
        clr = c;
        rst = r;
        @(posedge clk);
        model_step(0, rv, d, rdy, c, r);
        model_step(1, rv, d, rdy, c, r);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] exp_seq [5];
        ifa.flow_valid = 1'b0; ifa.flow_data = '0; ifa.stream_ready = 1'b0;
        ifb.flow_valid = 1'b0; ifb.flow_data = '0; ifb.stream_ready = 1'b0;
        clr = 1'b0;
        rst = 1'b1;

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", 64'(ifa.stream_valid), 64'd0);
        chk("reset_overflow", 64'(ovf_a), 64'd0);
        chk("reset_count", 64'(cnt_a), 64'd0);

        // Single beat latency
        step(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
        chk("s1_c1_valid", 64'(ifa.stream_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("s1_c2_valid", 64'(ifa.stream_valid), 64'd1);
        chk("s1_c2_data", 64'(ifa.stream_data), 64'hA5);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("s1_c3_valid", 64'(ifa.stream_valid), 64'd0);
        chk("s1_overflow", 64'(ovf_a), 64'd0);

        // Overflow with ready low, then drain
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) step(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
        chk("s2_overflow", 64'(ovf_a), 64'd1);
        chk("s2_count", 64'(cnt_a), CntEn ? 64'd1 : 64'd0);
        chk("s2_head", 64'(ifa.stream_data), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("s2_drain_valid", 64'(ifa.stream_valid), 64'd1);
            chk("s2_drain_data", 64'(ifa.stream_data), 64'(k));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("s2_empty", 64'(ifa.stream_valid), 64'd0);

        // Full buffer accepts when the head leaves in the same cycle
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 32'h10 + 32'(k), 1'b0, 1'b0, 1'b0);
        exp_seq = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h77};
        step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        chk("s3_no_drop", 64'(ovf_a), 64'd0);
        chk("s3_first", 64'(ifa.stream_data), 64'(exp_seq[0]));
        for (int k = 1; k < 5; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("s3_order", 64'(ifa.stream_data), 64'(exp_seq[k]));
        end

        // Saturation, clear, and clear coincident with a drop
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 25; k++) step(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0, 1'b0);
        chk("s4_sat", 64'(cnt_a), CntEn ? 64'd15 : 64'd0);
        chk("s4_overflow", 64'(ovf_a), 64'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("s4_clr_ovf", 64'(ovf_a), 64'd0);
        chk("s4_clr_cnt", 64'(cnt_a), 64'd0);
        step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
        chk("s4_clrdrop_ovf", 64'(ovf_a), 64'd1);
        chk("s4_clrdrop_cnt", 64'(cnt_a), CntEn ? 64'd1 : 64'd0);

        // Reset mid-operation discards everything
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0, 1'b0);
        chk("s5_pre_valid", 64'(ifa.stream_valid), 64'd1);
        step(1'b1, 32'h3FF, 1'b0, 1'b0, 1'b1);
        chk("s5_valid", 64'(ifa.stream_valid), 64'd0);
        chk("s5_ovf", 64'(ovf_a), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("s5_no_stale", 64'(ifa.stream_valid), 64'd0);
        end

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) < 70), $urandom(), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/flow_to_stream.md
# flow_to_stream

Adapter from the non-backpressured `flow` protocol to the backpressured `stream` protocol. It accepts one beat per cycle from a `flow` source, buffers the beats in a small circular buffer, and presents them in order on a `stream` sender. Beats that arrive when the buffer cannot take them are dropped, and the drop is reported. It sits at the boundary where free-running producers (decoders, sensors, counters) feed stream consumers and sfifo chains.

## Interface
Parameters:
- `T`, `logic[31:0]`: beat data type.
- `DEPTH`, 4: buffer entries, ≥2. Total capacity is DEPTH+1 (buffer plus output register).
- `COUNT_WIDTH`, 16: width of the drop counter.

Ports:
- `clock`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high.
- `receiver.valid`  input  1  flow beat present this cycle (`flow.receive` modport).
- `receiver.data`  input  T  flow beat payload.
- `sender.valid`  output  1  stream beat valid (`stream.send` modport).
- `sender.data`  output  T  stream beat payload.
- `sender.ready`  input  1  downstream accepts beat.
- `clear`  input  1  clears `overflow` and `drop_count`.
- `overflow`  output  1  sticky: at least one beat dropped since reset/clear.
- `drop_count`  output  COUNT_WIDTH  saturating count of dropped beats.

## Operation
- Internal: `fill` (0..DEPTH), `write_pointer`, `read_pointer` (0..DEPTH-1, wrap DEPTH-1→0, DEPTH need not be a power of two).
- `read_data = (!sender.valid || sender.ready) && fill!=0`: moves the head entry into the sender.data/valid register.
- `accept = receiver.valid && (fill<DEPTH || read_data)`: a full buffer still accepts when a read frees a slot in the same cycle.
- `drop = receiver.valid && !accept`: newest beat discarded; buffered beats never overwritten.
- `fill` changes by +1 on accept only, −1 on read only, and is unchanged on both or neither.
- `sender.valid`: set on `read_data`; cleared when `sender.ready && !read_data`; held otherwise. `sender.data` holds while valid && !ready.
- `overflow` is set on `drop`. `drop_count` increments on `drop` and saturates at 2^COUNT_WIDTH−1.
- `clear` zeroes both. If `drop` coincides with `clear`, the result is `overflow`=1 and `drop_count`=1 (the new event survives the clear).
- Reset: `sender.valid`=0, `overflow`=0, `drop_count`=0, fill/pointers=0. `sender.data` is undefined until the first valid. Buffer RAM is not reset.
- Reset mid-operation discards all buffered beats. `receiver.valid` is ignored while reset is high.

## Timing
- Latency from empty: a beat on `receiver` in cycle N appears with `sender.valid`=1 in cycle N+2.
- Throughput: one beat per cycle sustained with `sender.ready`=1.
- All outputs are registered; no combinational path from `receiver.*` or `sender.ready` to any output.
- `overflow` and `drop_count` reflect a drop in cycle N at cycle N+1.

## Configuration
- `FLOW_TO_STREAM_DROP_COUNT_EN` defined: the drop counter is implemented as described.
- Undefined: no counter register; `drop_count` is tied to 0. `overflow` and `clear` behave identically in both builds.

## Test plan
- DEPTH=4, ready=1, single beat 0xA5 at cycle 0 → sender.valid=1, data=0xA5 in cycle 2 only; overflow=0.
- ready=0, beats 1..6 on cycles 0–5 → beat 6 dropped; overflow=1 and drop_count=1 at cycle 6; then ready=1 → 1,2,3,4,5 on consecutive cycles, followed by sender.valid=0.
- Buffer full (fill=4, sender.valid=1), ready=1 with a simultaneous beat 0x77 → accepted, fill stays 4, no drop; 0x77 emerges after the 4 older beats.
- COUNT_WIDTH=4, 20 drops → drop_count=15 (saturated), overflow=1; pulse clear → both 0 next cycle. Clear coincident with a drop → overflow=1, drop_count=1.
- fill=3 with sender.valid=1; reset high 1 cycle with receiver.valid=1 → next cycle sender.valid=0, counters 0; no stale beat is ever output.
- Macro undefined, rerun scenario 2 → drop_count stays 0; overflow still 1 at cycle 6.
